// File: rtl/ram8_16.sv
// Eight-word register bank with combinational read, a one-word-per-cycle clear sweep and per-word dirty flags.
// Optional macro RAM8_16_BYPASS_EN: write-first forwarding of `in` to `out` while loading in IDLE.
module ram8_16 #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic [DEPTH_LOG2-1:0] address,
  input  logic                  clear,
  output logic [WIDTH-1:0]      out,
  output logic                  busy,
  output logic [7:0]            dirty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Handshake: none; load/clear are level-sampled commands, accepted only when busy is low.
  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] cnt, cnt_next;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  wr_en;
  logic [WIDTH-1:0]      lower_word, upper_word, read_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt + 1'b1;
        if (cnt == {DEPTH_LOG2{1'b1}}) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign wr_en = (state == IDLE) && load;
  assign busy  = (state == CLEAR);

  // A load coinciding with clear lands here first; the sweep erases it later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      dirty <= '0;
    end else if (state == CLEAR) begin
      mem[cnt]   <= '0;
      dirty[cnt] <= 1'b0;
    end else if (wr_en) begin
      mem[address]   <= in;
      dirty[address] <= 1'b1;
    end
  end

  // address[2] picks between the lower and upper four-word halves.
  assign lower_word = mem[{1'b0, address[DEPTH_LOG2-2:0]}];
  assign upper_word = mem[{1'b1, address[DEPTH_LOG2-2:0]}];
  assign read_word  = address[DEPTH_LOG2-1] ? upper_word : lower_word;

  always_comb begin
    out = read_word;
`ifdef RAM8_16_BYPASS_EN
    if (wr_en) out = in;
`endif
    if (busy) out = '0;
  end

endmodule

// File: tb/tb_ram8_16.sv
// Directed bench for ram8_16: reset, write/read, bypass behaviour, clear sweep, reset abort and load+clear overlap.
module tb_ram8_16;

  logic        clk;
  logic        rst;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;
  logic [7:0]  dirty;

  int vectors;
  int errors;
  int busy_cycles;

  ram8_16 dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy),
    .dirty   (dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    in      = '0;
    load    = 1'b0;
    address = '0;
    clear   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      chk($sformatf("reset_out_%0d", i), out, 16'h0000);
    end
    chk("reset_dirty", {8'h00, dirty}, 16'h0000);
    chk("reset_busy", {15'd0, busy}, 16'h0000);

    // Basic writes and reads
    write_word(3'd3, 16'h1234);
    write_word(3'd7, 16'hBEEF);
    address = 3'd3; #1;
    chk("read_3", out, 16'h1234);
    address = 3'd7; #1;
    chk("read_7", out, 16'hBEEF);
    chk("dirty_3_7", {8'h00, dirty}, 16'h0088);

    // Read-first versus write-first before the edge
    address = 3'd5;
    in      = 16'hA5A5;
    load    = 1'b1;
    #1;
`ifdef RAM8_16_BYPASS_EN
    chk("pre_edge_bypass", out, 16'hA5A5);
`else
    chk("pre_edge_no_bypass", out, 16'h0000);
`endif
    tick();
    load = 1'b0;
    #1;
    chk("post_edge_5", out, 16'hA5A5);
    chk("dirty_3_5_7", {8'h00, dirty}, 16'h00A8);

    // Fill every word, then sweep with blocked loads and a blocked restart
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'(16'h1111 * i + 1));
    address = 3'd6; #1;
    chk("fill_6", out, 16'h6667);
    chk("fill_dirty", {8'h00, dirty}, 16'h00FF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      busy_cycles++;
      address = 3'(k);
      in      = 16'hFFFF;
      load    = 1'b1;
      clear   = (k == 3);
      #1;
      chk($sformatf("sweep_out_%0d", k), out, 16'h0000);
      tick();
    end
    load  = 1'b0;
    clear = 1'b0;
    chk("sweep_busy_cycles", 16'(busy_cycles), 16'd8);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #1;
      chk($sformatf("swept_out_%0d", i), out, 16'h0000);
    end
    chk("swept_dirty", {8'h00, dirty}, 16'h0000);

    // Reset aborts a running sweep
    write_word(3'd6, 16'h4321);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy_start", {15'd0, busy}, 16'h0001);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'h0000);
    address = 3'd6; #1;
    chk("abort_word_6", out, 16'h0000);
    chk("abort_dirty", {8'h00, dirty}, 16'h0000);
    write_word(3'd2, 16'h2222);
    address = 3'd2; #1;
    chk("post_abort_write", out, 16'h2222);
    chk("post_abort_dirty", {8'h00, dirty}, 16'h0004);

    // Load and clear together: write lands, sweep erases it
    address = 3'd6;
    in      = 16'h7777;
    load    = 1'b1;
    clear   = 1'b1;
    tick();
    load  = 1'b0;
    clear = 1'b0;
    chk("overlap_busy", {15'd0, busy}, 16'h0001);
    chk("overlap_dirty", {8'h00, dirty}, 16'h0044);
    busy_cycles = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      busy_cycles++;
      tick();
    end
    chk("overlap_busy_cycles", 16'(busy_cycles), 16'd8);
    address = 3'd6; #1;
    chk("overlap_word_6", out, 16'h0000);
    chk("overlap_dirty_final", {8'h00, dirty}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
